// File: rtl/reg_file.sv
// Sequential signed 8x8 Booth radix-4 multiplier with serial operand load
// and a two-beat product output (high byte, then low byte).
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   start      level request, taken in IDLE
//   inbus      operand bus: multiplicand, then multiplier (signed)
//   final_beat high for one cycle, while the low product byte is on outbus
//   outbus     product beat, zero outside the output states
module reg_file (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] inbus,
  output logic       final_beat,
  output logic [8:0] outbus
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_M,
    LOAD_Q,
    ITER,
    OUT_HI,
    OUT_LO,
    DONE
  } state_t;

  state_t      state;
  logic [7:0]  m;
  logic [7:0]  q;
  logic [9:0]  a;
  logic        q1;
  logic [2:0]  count;

  logic [9:0]  m_ext;
  logic [9:0]  m_x2;
  logic [9:0]  addend;
  logic [9:0]  sum;
  logic [15:0] prod;

  assign m_ext = {{2{m[7]}}, m};
  assign m_x2  = {m_ext[8:0], 1'b0};

  always_comb begin
    addend = '0;
    unique case ({q[1:0], q1})
      3'b000,
      3'b111: addend = '0;
      3'b001,
      3'b010: addend = m_ext;
      3'b011: addend = m_x2;
      3'b100: addend = -m_x2;
      3'b101,
      3'b110: addend = -m_ext;
      default: addend = '0;
    endcase
  end

  assign sum  = a + addend;
  assign prod = {a[7:0], q};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      m     <= '0;
      q     <= '0;
      a     <= '0;
      q1    <= 1'b0;
      count <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start)
            state <= LOAD_M;
        end
        LOAD_M: begin
          m     <= inbus;
          state <= LOAD_Q;
        end
        LOAD_Q: begin
          q     <= inbus;
          a     <= '0;
          q1    <= 1'b0;
          count <= '0;
          state <= ITER;
        end
        ITER: begin
          // {sum,q,q1} arithmetic-shifted right by two
          a     <= {sum[9], sum[9], sum[9:2]};
          q     <= {sum[1:0], q[7:2]};
          q1    <= q[1];
          count <= count + 3'd1;
          if (count == 3'd3)
            state <= OUT_HI;
        end
        OUT_HI: state <= OUT_LO;
        OUT_LO: state <= DONE;
        DONE: begin
          // held start must not retrigger
          if (!start)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    outbus     = '0;
    final_beat = 1'b0;
    unique case (state)
      OUT_HI: outbus = {prod[15], prod[15:8]};
      OUT_LO: begin
        outbus     = {1'b0, prod[7:0]};
        final_beat = 1'b1;
      end
      default: begin
        outbus     = '0;
        final_beat = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_reg_file.sv
// Randomized bench for reg_file: products checked against
// plain integer multiplication, beat order and final alignment.
module tb_reg_file;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] inbus;
  logic       final_beat;
  logic [8:0] outbus;

  int ntests;
  int nfail;
  int pulses;

  reg_file dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .inbus      (inbus),
    .final_beat (final_beat),
    .outbus     (outbus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [15:0] got,
                     input logic [15:0] exp);
    ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_out"}, 16'(outbus), 16'h0);
    chk({tag, "_fin"}, 16'(final_beat), 16'h0);
  endtask

  // One operation starting from IDLE. abort>0 asserts reset
  // just after relative edge k+abort and leaves it high.
  task automatic run_op(input logic signed [7:0] mv,
                        input logic signed [7:0] qv,
                        input bit hold,
                        input int abort);
    logic [15:0] p;
    int pi;
    pi = int'(mv) * int'(qv);
    p  = pi[15:0];
    @(negedge clk);
    start = 1'b1;
    inbus = 8'($urandom);
    @(posedge clk);
    #1 chk_zero("lm");
    for (int e = 1; e <= 8; e++) begin
      @(negedge clk);
      if (e == 1)      inbus = mv;
      else if (e == 2) inbus = qv;
      else             inbus = 8'($urandom);
      start = 1'($urandom);
      @(posedge clk);
      #1;
      if (e == 6) begin
        chk("hi", 16'(outbus), 16'({p[15], p[15:8]}));
        chk("hi_fin", 16'(final_beat), 16'h0);
      end else if (e == 7) begin
        chk("lo", 16'(outbus), 16'({1'b0, p[7:0]}));
        chk("lo_fin", 16'(final_beat), 16'h1);
      end else begin
        chk_zero("mid");
      end
      if (e == abort) begin
        reset = 1'b1;
        #1 chk_zero("arst");
        return;
      end
    end
    @(negedge clk);
    start = hold;
    if (!hold) @(posedge clk);
  endtask

  always @(posedge clk) begin
    #1 if (final_beat === 1'b1) pulses++;
  end

  initial begin
    int p0;
    ntests = 0;
    nfail  = 0;
    pulses = 0;
    reset  = 1'b1;
    start  = 1'b0;
    inbus  = '0;
    repeat (2) @(posedge clk);
    #1 chk_zero("rst");
    @(negedge clk);
    reset = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1 chk_zero("idle");
    end

    run_op(8'sd6, 8'sd8, 1'b0, 0);
    run_op(-8'sd7, 8'sd5, 1'b0, 0);
    run_op(-8'sd128, -8'sd128, 1'b0, 0);
    run_op(8'sd127, -8'sd128, 1'b0, 0);
    run_op(8'sd0, -8'sd77, 1'b0, 0);

    // held start: exactly one final pulse for one operation
    p0 = pulses;
    run_op(8'sd9, -8'sd3, 1'b1, 0);
    repeat (20) begin
      @(posedge clk);
      #1 chk_zero("held");
    end
    chk("held_pulses", 16'(pulses - p0), 16'h1);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    run_op(-8'sd50, 8'sd41, 1'b0, 0);

    // reset in ITER (count=2), then in OUT_LO
    run_op(8'sd100, 8'sd99, 1'b0, 4);
    @(negedge clk);
    start = 1'b0;
    reset = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1 chk_zero("post_rst");
    end
    run_op(8'sd3, -8'sd4, 1'b0, 0);
    run_op(-8'sd33, 8'sd21, 1'b0, 7);
    @(negedge clk);
    start = 1'b0;
    reset = 1'b0;
    @(posedge clk);
    #1 chk_zero("post_rst2");

    p0 = pulses;
    for (int i = 0; i < 220; i++)
      run_op(8'($urandom), 8'($urandom), 1'b0, 0);
    chk("rand_pulses", 16'(pulses - p0), 16'd220);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
